// File: rtl/bus_load_arbiter_pkg.sv
// bus_arb_pkg: shared types and constants for the bus load arbiter.
//   state_t         : arbiter FSM state encoding
//   clog2/src_width : width helpers for the source index and watchdog counter
//   DEFAULT_TIMEOUT : default watchdog limit in cycles
package bus_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam int DEFAULT_TIMEOUT = 16;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Index width, never below one bit.
  function automatic int src_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/bus_load_arbiter_if.sv
// bus_load_arbiter_if: request/grant and downstream handshake bundle.
//   REQ, REQ_DATA : per-requester request level and packed data words
//   ACK_IN        : downstream accept
//   GNT           : one-hot grant pulse back to the requesters
//   OUT_VALID, OUT_DATA, OUT_SRC : captured word and its source index
//   BUSY, ERR     : transfer in progress / watchdog abort pulse
// Modports: slave = arbiter side, master = requester/downstream side.
interface bus_load_arbiter_if
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int SRC_W   = src_width(NUM_REQ)
) ();

  logic [NUM_REQ-1:0]        REQ;
  logic [NUM_REQ*DATA_W-1:0] REQ_DATA;
  logic                      ACK_IN;
  logic [NUM_REQ-1:0]        GNT;
  logic                      OUT_VALID;
  logic [DATA_W-1:0]         OUT_DATA;
  logic [SRC_W-1:0]          OUT_SRC;
  logic                      BUSY;
  logic                      ERR;

  modport slave (
    input  REQ, REQ_DATA, ACK_IN,
    output GNT, OUT_VALID, OUT_DATA, OUT_SRC, BUSY, ERR
  );

  modport master (
    output REQ, REQ_DATA, ACK_IN,
    input  GNT, OUT_VALID, OUT_DATA, OUT_SRC, BUSY, ERR
  );

endinterface

// File: rtl/bus_load_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req  : request vector (N bits)
//   ptr  : highest-priority index, must be < N
//   gnt  : one-hot winner
//   idx  : binary index of the winner
//   any  : at least one request set
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = src_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = W'(j);
      end
    end
  end

endmodule

// File: rtl/bus_load_arbiter.sv
// bus_load_arbiter: round-robin arbiter sharing one registered load stage.
//   CLK, RST_N : clock, asynchronous active-low reset
//   bus        : slave side of bus_load_arbiter_if (REQ/REQ_DATA/ACK_IN in,
//                GNT/OUT_VALID/OUT_DATA/OUT_SRC/BUSY/ERR out)
//
// state | meaning
// IDLE  | no word held, waiting for any request
// XFER  | word held on OUT_DATA, waiting for ACK_IN or watchdog expiry
module bus_load_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int SRC_W   = src_width(NUM_REQ)
) (
  input logic                CLK,
  input logic                RST_N,
  bus_load_arbiter_if.slave  bus
);

  localparam int CNT_W = src_width(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [SRC_W-1:0] SRC_LAST = SRC_W'(NUM_REQ - 1);

  state_t              state_q, state_d;
  logic [SRC_W-1:0]    ptr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic                valid_q;
  logic [DATA_W-1:0]   data_q;
  logic [SRC_W-1:0]    src_q;
  logic                err_q;

  logic [SRC_W-1:0]    ptr_adv;
  logic [SRC_W-1:0]    pick_ptr;
  logic [NUM_REQ-1:0]  eff_req;
  logic [NUM_REQ-1:0]  pick_gnt;
  logic [SRC_W-1:0]    pick_idx;
  logic                pick_any;
  logic [DATA_W-1:0]   sel_data;

  logic                complete;
  logic                timeout_hit;
  logic                load;
  logic                advance;
  logic                drop;

  // Pointer after the current transfer, wrapping at NUM_REQ-1.
  assign ptr_adv  = (src_q == SRC_LAST) ? '0 : src_q + SRC_W'(1);
  // Back-to-back re-arbitration must already see the advanced pointer.
  assign pick_ptr = (state_q == XFER) ? ptr_adv : ptr_q;
  // The requester being granted this cycle may still hold REQ high.
  assign eff_req  = bus.REQ & ~gnt_q;

  rr_pick #(.N(NUM_REQ), .W(SRC_W)) u_pick (
    .req (eff_req),
    .ptr (pick_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) sel_data = bus.REQ_DATA[i*DATA_W +: DATA_W];
    end
  end

  assign complete    = (state_q == XFER) && bus.ACK_IN;
  assign timeout_hit = (TIMEOUT > 0) && (state_q == XFER) && !bus.ACK_IN
                       && (cnt_q == CNT_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (pick_any) state_d = XFER;
      XFER: begin
        if (complete)         state_d = pick_any ? XFER : IDLE;
        else if (timeout_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load    = 1'b0;
    advance = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: load = pick_any;
      XFER: begin
        load    = complete && pick_any;
        advance = complete || timeout_hit;
        drop    = (complete && !pick_any) || timeout_hit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if (advance) ptr_q <= ptr_adv;

      if (load) begin
        gnt_q   <= pick_gnt;
        valid_q <= 1'b1;
        data_q  <= sel_data;
        src_q   <= pick_idx;
      end else begin
        gnt_q <= '0;
        if (drop) valid_q <= 1'b0;
      end

      if ((TIMEOUT > 0) && (state_q == XFER) && !bus.ACK_IN && !timeout_hit)
        cnt_q <= cnt_q + CNT_W'(1);
      else
        cnt_q <= '0;
    end
  end

  assign bus.GNT       = gnt_q;
  assign bus.OUT_VALID = valid_q;
  assign bus.OUT_DATA  = data_q;
  assign bus.OUT_SRC   = src_q;
  assign bus.BUSY      = (state_q == XFER);
  assign bus.ERR       = err_q;

endmodule

// File: tb/tb_bus_load_arbiter.sv
// tb_bus_load_arbiter: directed bench for bus_load_arbiter.
// dut_a (TIMEOUT=16) covers reset, rotation, single request, wrap fairness and
// backpressure; dut_b (TIMEOUT=4) covers watchdog abort and reset mid-transfer.
module tb_bus_load_arbiter;

  logic clk;
  logic rst_n_a;
  logic rst_n_b;
  int   n_cmp;
  int   n_err;

  bus_load_arbiter_if #(.NUM_REQ(4), .DATA_W(32)) a_if ();
  bus_load_arbiter_if #(.NUM_REQ(4), .DATA_W(32)) b_if ();

  bus_load_arbiter #(.NUM_REQ(4), .DATA_W(32), .TIMEOUT(16)) dut_a (
    .CLK   (clk),
    .RST_N (rst_n_a),
    .bus   (a_if)
  );

  bus_load_arbiter #(.NUM_REQ(4), .DATA_W(32), .TIMEOUT(4)) dut_b (
    .CLK   (clk),
    .RST_N (rst_n_b),
    .bus   (b_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    a_if.REQ      = 4'b1111;
    a_if.REQ_DATA = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h1000_0000};
    a_if.ACK_IN   = 1'b1;
    b_if.REQ      = 4'b0000;
    b_if.REQ_DATA = {32'hB3B3_0003, 32'hB2B2_0002, 32'hB1B1_0001, 32'hB0B0_0000};
    b_if.ACK_IN   = 1'b0;

    // Reset held with all requests high.
    tick(); tick();
    chk("rst_gnt",   32'(a_if.GNT), 32'h0);
    chk("rst_valid", 32'(a_if.OUT_VALID), 32'h0);
    chk("rst_busy",  32'(a_if.BUSY), 32'h0);
    chk("rst_err",   32'(a_if.ERR), 32'h0);
    chk("rst_data",  a_if.OUT_DATA, 32'h0);

    // Rotation 0,1,2,3 with each requester dropping after its grant.
    rst_n_a = 1'b1;
    tick();
    chk("rot0_gnt",  32'(a_if.GNT), 32'h1);
    chk("rot0_src",  32'(a_if.OUT_SRC), 32'd0);
    chk("rot0_data", a_if.OUT_DATA, 32'h1000_0000);
    chk("rot0_valid", 32'(a_if.OUT_VALID), 32'h1);
    a_if.REQ = 4'b1110;
    tick();
    chk("rot1_gnt",  32'(a_if.GNT), 32'h2);
    chk("rot1_data", a_if.OUT_DATA, 32'h1111_1111);
    chk("rot1_valid", 32'(a_if.OUT_VALID), 32'h1);
    a_if.REQ = 4'b1100;
    tick();
    chk("rot2_gnt",  32'(a_if.GNT), 32'h4);
    chk("rot2_src",  32'(a_if.OUT_SRC), 32'd2);
    chk("rot2_valid", 32'(a_if.OUT_VALID), 32'h1);
    a_if.REQ = 4'b1000;
    tick();
    chk("rot3_gnt",  32'(a_if.GNT), 32'h8);
    chk("rot3_data", a_if.OUT_DATA, 32'h3333_3333);
    chk("rot3_valid", 32'(a_if.OUT_VALID), 32'h1);
    a_if.REQ = 4'b0000;
    tick();
    chk("rot_end_valid", 32'(a_if.OUT_VALID), 32'h0);
    chk("rot_end_busy",  32'(a_if.BUSY), 32'h0);
    chk("rot_end_gnt",   32'(a_if.GNT), 32'h0);

    // Single request from requester 2.
    a_if.REQ = 4'b0100;
    tick();
    chk("single_gnt",   32'(a_if.GNT), 32'h4);
    chk("single_valid", 32'(a_if.OUT_VALID), 32'h1);
    chk("single_data",  a_if.OUT_DATA, 32'hDEAD_BEEF);
    chk("single_src",   32'(a_if.OUT_SRC), 32'd2);
    chk("single_busy",  32'(a_if.BUSY), 32'h1);
    a_if.REQ = 4'b0000;
    tick();
    chk("single_end_valid", 32'(a_if.OUT_VALID), 32'h0);
    chk("single_end_busy",  32'(a_if.BUSY), 32'h0);

    // Pointer is now 3: requester 3 beats requester 0, then 0 follows.
    a_if.REQ = 4'b1001;
    tick();
    chk("wrap_first_gnt", 32'(a_if.GNT), 32'h8);
    chk("wrap_first_src", 32'(a_if.OUT_SRC), 32'd3);
    a_if.REQ = 4'b0001;
    tick();
    chk("wrap_second_gnt",  32'(a_if.GNT), 32'h1);
    chk("wrap_second_data", a_if.OUT_DATA, 32'h1000_0000);
    a_if.REQ = 4'b0000;
    tick();
    chk("wrap_end_valid", 32'(a_if.OUT_VALID), 32'h0);

    // Backpressure: five stalled cycles, completion on the sixth.
    a_if.REQ_DATA[63:32] = 32'hCAFE_F00D;
    a_if.REQ = 4'b0010;
    tick();
    chk("bp_gnt",  32'(a_if.GNT), 32'h2);
    chk("bp_data", a_if.OUT_DATA, 32'hCAFE_F00D);
    a_if.REQ    = 4'b0000;
    a_if.ACK_IN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", 32'(a_if.OUT_VALID), 32'h1);
      chk("bp_hold_data",  a_if.OUT_DATA, 32'hCAFE_F00D);
      chk("bp_hold_src",   32'(a_if.OUT_SRC), 32'd1);
      chk("bp_hold_gnt",   32'(a_if.GNT), 32'h0);
      chk("bp_hold_err",   32'(a_if.ERR), 32'h0);
    end
    a_if.ACK_IN = 1'b1;
    tick();
    chk("bp_done_valid", 32'(a_if.OUT_VALID), 32'h0);
    chk("bp_done_busy",  32'(a_if.BUSY), 32'h0);
    chk("bp_done_err",   32'(a_if.ERR), 32'h0);
    tick();
    chk("bp_after_err",  32'(a_if.ERR), 32'h0);

    // Watchdog on dut_b: ACK stuck low, limit 4 cycles.
    rst_n_b = 1'b1;
    b_if.REQ = 4'b0001;
    tick();
    chk("wd_gnt",   32'(b_if.GNT), 32'h1);
    chk("wd_valid", 32'(b_if.OUT_VALID), 32'h1);
    b_if.REQ = 4'b0011;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("wd_stall_valid", 32'(b_if.OUT_VALID), 32'h1);
      chk("wd_stall_err",   32'(b_if.ERR), 32'h0);
      chk("wd_stall_gnt",   32'(b_if.GNT), 32'h0);
    end
    tick();
    chk("wd_abort_valid", 32'(b_if.OUT_VALID), 32'h0);
    chk("wd_abort_err",   32'(b_if.ERR), 32'h1);
    chk("wd_abort_busy",  32'(b_if.BUSY), 32'h0);
    tick();
    chk("wd_next_err",  32'(b_if.ERR), 32'h0);
    chk("wd_next_gnt",  32'(b_if.GNT), 32'h2);
    chk("wd_next_src",  32'(b_if.OUT_SRC), 32'd1);
    chk("wd_next_data", b_if.OUT_DATA, 32'hB1B1_0001);
    b_if.REQ = 4'b0000;

    // Reset pulse in the middle of the stalled transfer.
    tick();
    chk("wd_mid_valid", 32'(b_if.OUT_VALID), 32'h1);
    #2;
    rst_n_b = 1'b0;
    #1;
    chk("rstmid_valid", 32'(b_if.OUT_VALID), 32'h0);
    chk("rstmid_err",   32'(b_if.ERR), 32'h0);
    chk("rstmid_busy",  32'(b_if.BUSY), 32'h0);
    tick();
    rst_n_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rstmid_after_err",   32'(b_if.ERR), 32'h0);
      chk("rstmid_after_valid", 32'(b_if.OUT_VALID), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_load_arbiter.md
Name: bus_load_arbiter

Overview:
- Round-robin arbiter that shares one registered bus load stage among NUM_REQ requesters; the load stage is a CLK-driven, non-blocking register bank such as the 32-bit bus register cell.
- Captures the winning requester's data word and presents it downstream with a valid/ack handshake.
- Returns a one-cycle grant to the winner.
- Aborts stalled transfers with a watchdog and reports each abort on ERR.

Parameters:
- NUM_REQ, 4: number of requesters, 2..16.
- DATA_W, 32: data word width.
- TIMEOUT, 16: maximum cycles OUT_VALID may wait for ACK_IN. 0 disables the watchdog.
- SRC_W, derived as max(1, clog2(NUM_REQ)): width of the source index.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  reset, asynchronous assert, active low.
- REQ  input  NUM_REQ  per-requester request, level.
- REQ_DATA  input  NUM_REQ*DATA_W  packed data; requester i owns bits [i*DATA_W +: DATA_W].
- ACK_IN  input  1  downstream accepts OUT_DATA this cycle.
- GNT  output  NUM_REQ  one-hot grant pulse, registered.
- OUT_VALID  output  1  OUT_DATA/OUT_SRC valid.
- OUT_DATA  output  DATA_W  captured word.
- OUT_SRC  output  SRC_W  index of the captured requester.
- BUSY  output  1  high whenever state != IDLE.
- ERR  output  1  one-cycle pulse when a transfer is aborted by the watchdog.

Behaviour:
- Reset: while RST_N=0, all outputs are 0, state=IDLE, round-robin pointer PTR=0, watchdog counter=0.
- States: IDLE and XFER.
- Arbitration: winner = first set bit of the effective request vector, searching from PTR upward and wrapping modulo NUM_REQ. Arbitration is combinational and performed by rr_pick.
- IDLE: if any REQ bit is set at edge t:
  - state->XFER.
  - OUT_DATA<=REQ_DATA[winner], OUT_SRC<=winner, OUT_VALID<=1.
  - GNT<=onehot(winner) for exactly the cycle after edge t.
  - Latency from REQ to OUT_VALID is 1 cycle.
- Requester contract:
  - Hold REQ and data stable until GNT is seen.
  - REQ may remain high during the GNT cycle.
  - The arbiter masks the granted bit out of the effective request vector while GNT is high.
- XFER with ACK_IN=1:
  - Transfer completes and PTR<=(OUT_SRC+1) mod NUM_REQ.
  - If any unmasked REQ bit is set, re-arbitrate in the same edge using the new PTR. State stays XFER, a new word is loaded and a new GNT pulse is issued (back-to-back, 1 word per cycle).
  - Otherwise OUT_VALID<=0 and state->IDLE.
- XFER with ACK_IN=0: OUT_DATA, OUT_SRC and OUT_VALID hold; GNT=0; the watchdog counter increments.
- Watchdog (TIMEOUT>0): on the edge where the counter reaches TIMEOUT with ACK_IN still 0:
  - OUT_VALID<=0, ERR<=1 for one cycle, state->IDLE.
  - PTR advances as on completion, so the stalled requester loses priority.
  - The counter clears on every completion and every abort.
- ACK_IN while OUT_VALID=0 is ignored.
- A single requester that holds REQ continuously is re-granted every other cycle at most, because of GNT masking.
- Reset mid-transfer: OUT_VALID drops asynchronously. The word is lost and no ERR is raised.
- If NUM_REQ is not a power of 2, the pointer wraps at NUM_REQ-1 -> 0, and OUT_SRC never exceeds NUM_REQ-1.

Decomposition:
- Package bus_arb_pkg holds:
  - the state enum {IDLE=1'b0, XFER=1'b1};
  - a clog2 function for SRC_W;
  - the constant DEFAULT_TIMEOUT=16.
- Sub-module rr_pick (parameter N): combinational round-robin picker. Inputs: request vector, pointer. Outputs: one-hot grant, binary index, any-valid. It is instantiated once.

Test Plan:
- Reset: RST_N=0 with REQ=4'b1111 -> GNT=0, OUT_VALID=0, BUSY=0, ERR=0. Release RST_N, and the first grant goes to requester 0.
- Single request: REQ=4'b0100 with D2=32'hDEADBEEF, ACK_IN=1 -> next cycle GNT=4'b0100, OUT_VALID=1, OUT_DATA=32'hDEADBEEF, OUT_SRC=2. The cycle after that, OUT_VALID=0 and BUSY=0.
- Round-robin rotation: REQ=4'b1111 held, with each requester dropping its REQ after its GNT, ACK_IN=1 -> grants in order 0,1,2,3 on consecutive cycles, OUT_VALID continuously 1.
- Fairness after wrap: PTR=3 and REQ=4'b1001 -> requester 3 is granted first, then requester 0.
- Backpressure: ACK_IN=0 for 5 cycles with TIMEOUT=16 -> OUT_DATA and OUT_SRC stable, no GNT. ACK_IN=1 on cycle 6 -> completes with ERR=0.
- Watchdog: ACK_IN stuck at 0 with TIMEOUT=4 -> OUT_VALID drops 4 cycles after assertion, ERR pulses for 1 cycle, and the next grant goes to the next requester in round-robin order. A repeat run with RST_N pulsed low mid-XFER -> OUT_VALID=0 immediately and no ERR.
